// File: rtl/score_display_pkg.sv
// Shared constants and helpers for the score display: segment table,
// blank pattern, game-state bit positions and the hit popcount.
package score_display_pkg;

  localparam logic [7:0]  SSD_BLANK = 8'hFF;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // Bit positions inside the packed {lose, win, playing, start} state vector
  localparam int ST_START   = 0;
  localparam int ST_PLAYING = 1;
  localparam int ST_WIN     = 2;
  localparam int ST_LOSE    = 3;

  typedef logic [3:0] bcd_digit_t;

  // Active-low cathodes {a,b,c,d,e,f,g,dp}; decimal point always off
  function automatic logic [7:0] seg_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return {s, 1'b1};
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/score_display_bcd_add_sat.sv
// Combinational 4-digit BCD plus a 0..3 increment, clamped at 9999.
module bcd_add_sat
  import score_display_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [1:0]  i_inc,
  output logic [15:0] o_sum
);

  logic [15:0] w_raw;
  logic [1:0]  w_c;
  logic [4:0]  w_t;

  // Ripple the increment through the digits; any carry out of digit 3 saturates
  always_comb begin
    w_raw = 16'h0000;
    w_c   = i_inc;
    w_t   = 5'd0;
    for (int i = 0; i < 4; i++) begin
      w_t = {1'b0, i_a[4*i +: 4]} + {3'b000, w_c};
      if (w_t > 5'd9) begin
        w_raw[4*i +: 4] = w_t[3:0] - 4'd10;
        w_c             = 2'd1;
      end else begin
        w_raw[4*i +: 4] = w_t[3:0];
        w_c             = 2'd0;
      end
    end
    if (w_c != 2'd0) begin
      o_sum = BCD_MAX;
    end else begin
      o_sum = w_raw;
    end
  end

endmodule

// File: rtl/score_display.sv
// Game score keeper with high-score latch and an 8-digit multiplexed
// seven-segment driver (score on digits 0..3, high score on 4..7).
module score_display
  import score_display_pkg::*;
#(
  parameter int SCAN_DIV  = 18,
  parameter int BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  enemy_hit,
  input  logic        game_start,
  input  logic        game_playing,
  input  logic        game_win,
  input  logic        game_lose,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic [7:0]  an,
  output logic [7:0]  cath
);

  localparam int SCAN_W  = SCAN_DIV + 3;
  localparam int BLINK_W = BLINK_DIV + 1;

  logic [3:0]         w_state;
  logic [3:0]         r_state_prev;
  logic               w_start_rise;
  logic               w_end_entry;
  logic [1:0]         w_inc;
  logic [15:0]        w_sum;
  logic [15:0]        w_score_nxt;
  logic [SCAN_W-1:0]  r_scan;
  logic [BLINK_W-1:0] r_blink;
  logic [2:0]         w_digit;
  logic [3:0]         w_nibble;
  logic               w_blank;
  logic               w_blink_off;
  logic [7:0]         w_an_nxt;
  logic [7:0]         w_cath_nxt;

  assign w_state[ST_START]   = game_start;
  assign w_state[ST_PLAYING] = game_playing;
  assign w_state[ST_WIN]     = game_win;
  assign w_state[ST_LOSE]    = game_lose;

  assign w_start_rise = w_state[ST_START] & ~r_state_prev[ST_START];
  assign w_end_entry  = (w_state[ST_WIN]  & ~r_state_prev[ST_WIN]) |
                        (w_state[ST_LOSE] & ~r_state_prev[ST_LOSE]);
  assign w_inc        = game_playing ? popcount3(enemy_hit) : 2'd0;

  bcd_add_sat u_add (
    .i_a   (score_bcd),
    .i_inc (w_inc),
    .o_sum (w_sum)
  );

  // Start wins over a same-cycle hit
  always_comb begin
    w_score_nxt = w_sum;
    if (w_start_rise) begin
      w_score_nxt = 16'h0000;
    end else begin
      w_score_nxt = w_sum;
    end
  end

  // Previous state bits for start and win/lose edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_prev <= 4'b0000;
    end else begin
      r_state_prev <= w_state;
    end
  end

  // Score register and high-score latch; the compared score already includes this cycle's hits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= 16'h0000;
      high_bcd  <= 16'h0000;
    end else begin
      score_bcd <= w_score_nxt;
      if (w_end_entry && (w_score_nxt > high_bcd)) begin
        high_bcd <= w_score_nxt;
      end
    end
  end

  // Free-running digit scan and blink phase; blink restarts on every win/lose entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan  <= '0;
      r_blink <= '0;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
      if (w_end_entry) begin
        r_blink <= '0;
      end else begin
        r_blink <= r_blink + BLINK_W'(1);
      end
    end
  end

  assign w_digit     = r_scan[SCAN_W-1:SCAN_DIV];
  assign w_blink_off = (game_win | game_lose) & r_blink[BLINK_DIV];

  // Digit source selection with leading-zero blanking on score digits 3..1
  always_comb begin
    w_nibble = 4'd0;
    w_blank  = 1'b0;
    case (w_digit)
      3'd0: begin
        w_nibble = score_bcd[3:0];
        w_blank  = w_blink_off;
      end
      3'd1: begin
        w_nibble = score_bcd[7:4];
        w_blank  = w_blink_off | (score_bcd[15:4] == 12'h000);
      end
      3'd2: begin
        w_nibble = score_bcd[11:8];
        w_blank  = w_blink_off | (score_bcd[15:8] == 8'h00);
      end
      3'd3: begin
        w_nibble = score_bcd[15:12];
        w_blank  = w_blink_off | (score_bcd[15:12] == 4'h0);
      end
      3'd4:    w_nibble = high_bcd[3:0];
      3'd5:    w_nibble = high_bcd[7:4];
      3'd6:    w_nibble = high_bcd[11:8];
      3'd7:    w_nibble = high_bcd[15:12];
      default: begin
        w_nibble = 4'd0;
        w_blank  = 1'b1;
      end
    endcase
  end

  assign w_an_nxt   = ~(8'd1 << w_digit);
  assign w_cath_nxt = w_blank ? SSD_BLANK : seg_decode(w_nibble);

  // Registered display drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an   <= 8'hFF;
      cath <= SSD_BLANK;
    end else begin
      an   <= w_an_nxt;
      cath <= w_cath_nxt;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Randomized and directed bench for score_display against a decimal-arithmetic
// reference model of score, high score and the expected display pattern.
module tb_score_display;

  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_START = 4'b0001;
  localparam logic [3:0] S_PLAY  = 4'b0010;
  localparam logic [3:0] S_WIN   = 4'b0100;
  localparam logic [3:0] S_LOSE  = 4'b1000;

  logic        clk;
  logic        reset_n;
  logic [2:0]  enemy_hit;
  logic        game_start, game_playing, game_win, game_lose;
  logic [15:0] score_bcd, high_bcd;
  logic [7:0]  an, cath;

  int n_cmp = 0;
  int n_err = 0;

  int m_score, m_high, m_scan, m_blink;
  logic [3:0] m_prev;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};
  int pow10 [4] = '{1, 10, 100, 1000};

  score_display #(.SCAN_DIV(2), .BLINK_DIV(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enemy_hit    (enemy_hit),
    .game_start   (game_start),
    .game_playing (game_playing),
    .game_win     (game_win),
    .game_lose    (game_lose),
    .score_bcd    (score_bcd),
    .high_bcd     (high_bcd),
    .an           (an),
    .cath         (cath)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int popcnt(input logic [2:0] h);
    return int'(h[0]) + int'(h[1]) + int'(h[2]);
  endfunction

  // One clock: apply inputs, predict display from pre-edge model, check, advance model
  task automatic step(input logic [2:0] hit, input logic [3:0] st);
    int         dig, val, d;
    logic       blank, start_rise, entry;
    logic [7:0] exp_an, exp_cath;
    enemy_hit = hit;
    {game_lose, game_win, game_playing, game_start} = st;
    dig    = (m_scan / 4) % 8;
    exp_an = ~(8'd1 << dig);
    if (dig < 4) begin
      val   = m_score;
      d     = dig;
      blank = (d > 0 && m_score < pow10[d]) ||
              ((st[2] || st[3]) && (((m_blink >> 4) & 1) == 1));
    end else begin
      val   = m_high;
      d     = dig - 4;
      blank = 1'b0;
    end
    exp_cath = blank ? 8'hFF : {seg_tab[(val / pow10[d]) % 10], 1'b1};
    @(posedge clk);
    #1;
    chk("an", {24'd0, an}, {24'd0, exp_an});
    chk("cath", {24'd0, cath}, {24'd0, exp_cath});
    start_rise = st[0] && !m_prev[0];
    entry      = (st[2] && !m_prev[2]) || (st[3] && !m_prev[3]);
    if (start_rise) m_score = 0;
    else if (st[1]) m_score = (m_score + popcnt(hit) > 9999) ? 9999 : m_score + popcnt(hit);
    if (entry && m_score > m_high) m_high = m_score;
    m_blink = entry ? 0 : m_blink + 1;
    m_scan++;
    m_prev = st;
    chk("score", {16'd0, score_bcd}, {16'd0, to_bcd(m_score)});
    chk("high", {16'd0, high_bcd}, {16'd0, to_bcd(m_high)});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_an", {24'd0, an}, 32'h0000_00FF);
    chk("rst_cath", {24'd0, cath}, 32'h0000_00FF);
    chk("rst_score", {16'd0, score_bcd}, 32'h0000_0000);
    chk("rst_high", {16'd0, high_bcd}, 32'h0000_0000);
    m_score = 0; m_high = 0; m_scan = 0; m_blink = 0; m_prev = 4'b0000;
    enemy_hit = 3'b000;
    {game_lose, game_win, game_playing, game_start} = S_IDLE;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    enemy_hit = 3'b000;
    {game_lose, game_win, game_playing, game_start} = S_IDLE;
    #1;
    do_reset();

    // Single triple hit
    step(3'b111, S_PLAY);
    chk("hit3", {16'd0, score_bcd}, 32'h0000_0003);

    // Carry through all digits
    step(3'b000, S_START);
    step(3'b000, S_PLAY);
    for (int i = 0; i < 332; i++) step(3'b111, S_PLAY);
    step(3'b011, S_PLAY);
    chk("pre0998", {16'd0, score_bcd}, 32'h0000_0998);
    step(3'b011, S_PLAY);
    chk("carry1000", {16'd0, score_bcd}, 32'h0000_1000);

    // Saturation at 9999
    for (int i = 0; i < 2999; i++) step(3'b111, S_PLAY);
    step(3'b001, S_PLAY);
    chk("pre9998", {16'd0, score_bcd}, 32'h0000_9998);
    step(3'b111, S_PLAY);
    chk("sat9999", {16'd0, score_bcd}, 32'h0000_9999);
    for (int i = 0; i < 5; i++) step(3'b111, S_PLAY);
    chk("sat_hold", {16'd0, score_bcd}, 32'h0000_9999);

    // High score latch on loss, not lowered by a worse game; blink while lost
    do_reset();
    step(3'b000, S_START);
    for (int i = 0; i < 14; i++) step(3'b111, S_PLAY);
    step(3'b000, S_LOSE);
    chk("high42", {16'd0, high_bcd}, 32'h0000_0042);
    for (int i = 0; i < 40; i++) step(3'b111, S_LOSE);
    chk("lose_ignore", {16'd0, score_bcd}, 32'h0000_0042);
    step(3'b000, S_START);
    step(3'b111, S_PLAY);
    step(3'b111, S_PLAY);
    step(3'b001, S_PLAY);
    step(3'b000, S_LOSE);
    chk("score7", {16'd0, score_bcd}, 32'h0000_0007);
    chk("high_keep", {16'd0, high_bcd}, 32'h0000_0042);
    for (int i = 0; i < 20; i++) step(3'b000, S_WIN);

    // Display walk with score 5
    do_reset();
    step(3'b011, S_PLAY);
    step(3'b111, S_PLAY);
    for (int i = 0; i < 34; i++) begin
      step(3'b000, S_PLAY);
      if (an == 8'hFE) chk("d0_cath", {24'd0, cath}, 32'h0000_0049);
      else if (an == 8'hFD || an == 8'hFB || an == 8'hF7) chk("lz_cath", {24'd0, cath}, 32'h0000_00FF);
    end

    // Start edge beats a same-cycle hit
    step(3'b001, S_START | S_PLAY);
    chk("start_prio", {16'd0, score_bcd}, 32'h0000_0000);
    step(3'b000, S_PLAY);
    step(3'b101, S_PLAY);
    step(3'b010, S_PLAY);

    // Asynchronous reset mid-scan
    do_reset();

    // Random game sessions
    for (int blk = 0; blk < 150; blk++) begin
      logic [3:0] st;
      int         len;
      st  = 4'b0001 << $urandom_range(0, 3);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        logic [2:0] h;
        h = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        step(h, st);
      end
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCAN_DIV, default 18, log2 of clock cycles each display digit is lit.
REQ-002 Parameter BLINK_DIV, default 25, log2 of the half-period of the win/lose blink, in clocks.
REQ-003 clk  input  1  system clock, 100 MHz; one clock domain, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enemy_hit  input  3  one-cycle hit pulses, one bit per enemy; several bits may be set in the same cycle.
REQ-006 game_start, game_playing, game_win, game_lose  input  1 each  one-hot game state levels.
REQ-007 score_bcd  output  16  current score, 4 BCD digits, digit 3 is most significant.
REQ-008 high_bcd  output  16  high score, 4 BCD digits.
REQ-009 an  output  8  digit anodes, active-low, an[0] is the rightmost digit.
REQ-010 cath  output  8  cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Function
REQ-011 Each cycle, score adds popcount(enemy_hit) (0..3) as a BCD add, and the result appears on score_bcd one cycle after the pulse.
REQ-012 The BCD add carries across all 4 digits and saturates at 9999; no wrap to 0000 is allowed.
REQ-013 Hits count only while game_playing=1; hits in any other state are ignored.
REQ-014 The rising edge of game_start clears score to 0000 on the next cycle; start has priority over a hit in the same cycle.
REQ-015 An internal edge detector registers the previous state bits; the entry into win or lose is one event, not a level.
REQ-016 On entry to game_win or game_lose, if score > high, high_bcd loads score on the next cycle.
REQ-017 A hit in the same cycle as the win/lose entry is already counted in the score that is compared.
REQ-018 Scan counter width is SCAN_DIV+3 bits; bits [SCAN_DIV+2:SCAN_DIV] select the active digit 0..7.
REQ-019 The scan counter free-runs and wraps from digit 7 to digit 0.
REQ-020 Digits 0..3 show score_bcd; digits 4..7 show high_bcd.
REQ-021 Leading-zero blanking applies to the score digits 3..1 only; digit 0 always shows, so a zero score displays "0".
REQ-022 A blank digit drives cath=8'hFF and keeps its anode asserted.
REQ-023 The high-score digits never blank.
REQ-024 In game_win or game_lose, the score digits blink: while blink counter bit BLINK_DIV is 1, cath=8'hFF for digits 0..3.
REQ-025 The blink counter resets to zero on each win/lose entry.
REQ-026 Dp is always 1 (decimal point off).
REQ-027 an and cath are registered, so exactly one an bit is 0 at any time after the first post-reset cycle.
REQ-028 Digit encoding, cath[7:1] = abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.

Reset
REQ-029 reset_n=0 forces asynchronously: score_bcd=16'h0000, high_bcd=16'h0000, scan and blink counters=0, edge-detect registers=0, an=8'hFF, cath=8'hFF.
REQ-030 After reset_n deasserts, digit 0 is driven starting on the first clock edge.
REQ-031 Reset asserted mid-game discards the score and the high score; no pending hit survives reset.

Structure
REQ-032 A shared package holds the BCD-to-segment table, the SSD_BLANK=8'hFF constant, and the state-bit index constants.
REQ-033 One sub-module, bcd_add_sat, is natural: combinational, 16-bit BCD plus 2-bit increment, saturating at 9999.
REQ-034 Segment decode is a function in the package, not a module.

Verification (bench uses SCAN_DIV=2, BLINK_DIV=4)
REQ-035 Reset, then game_playing=1 and enemy_hit=3'b111 for one cycle -> score_bcd=16'h0003 one cycle later.
REQ-036 Preload score 0998 by hits, then enemy_hit=3'b011 -> score_bcd=16'h1000 (carry through all digits).
REQ-037 Score 9998, then enemy_hit=3'b111 -> score_bcd=16'h9999 and it stays 9999 on further hits.
REQ-038 Score 0042, then game_playing->game_lose -> high_bcd=16'h0042; next game scores 0007 and loses -> high_bcd stays 16'h0042.
REQ-039 Score 0005 while playing -> the an sequence walks FE,FD,FB,...,7F every 4 cycles; digit 0 cath=8'b01001001; digits 1..3 cath=8'hFF.
REQ-040 game_start rising edge in the same cycle as enemy_hit=3'b001 -> score_bcd=16'h0000; reset_n pulsed low mid-scan -> an=8'hFF immediately, before any clock edge.
